// File: rtl/rs485_apb_rx_controller.sv
// rs485_apb_rx_controller: 8N1 RS485 receiver, 16-bit packet FIFO, APB regs.
// Optional RX_TIMEOUT_EN: drops a lone low byte after TIMEOUT_BITS idle bits.
module rs485_apb_rx_controller #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 16,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        PCLK,
  input  logic        PRESETN,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [7:0]  PADDR,
  input  logic [15:0] PWDATA,
  output logic        PREADY,
  output logic [15:0] PRDATA,
  input  logic        Rx,
  output logic        Rx_Active,
  output logic        rx_irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);

  localparam logic [BW-1:0] HALF = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] FULL = BW'(CLKS_PER_BIT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic          rx_s1;
  logic          rx;
  logic [1:0]    state;
  logic          armed;
  logic [BW-1:0] bit_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic [7:0]    low_byte;
  logic          have_low;
  logic          push_req;
  logic [15:0]   push_data;

  logic          enable;
  logic          frame_err;
  logic          overrun;
  logic          timeout_err;

  logic [15:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic expire;
  logic frame_ev;
  logic tmo_ev;
  logic ovr_ev;

  logic access;
  logic rd;
  logic wr;
  logic sel_data;
  logic sel_count;
  logic sel_status;
  logic sel_ctrl;
  logic empty;
  logic full;
  logic pop;
  logic push_ok;
  logic flush;
  logic clr;

  logic unused_wdata;

  assign unused_wdata = ^PWDATA[15:3];

  assign expire   = (bit_cnt == '0);
  assign frame_ev = enable && state == S_STOP
                    && expire && !rx;

  assign access     = PSEL & PENABLE;
  assign rd         = access & ~PWRITE;
  assign wr         = access & PWRITE;
  assign sel_data   = (PADDR == 8'h00);
  assign sel_count  = (PADDR == 8'h04);
  assign sel_status = (PADDR == 8'h08);
  assign sel_ctrl   = (PADDR == 8'h0C);

  assign empty   = (count == '0);
  assign full    = (count == CW'(FIFO_DEPTH));
  assign pop     = rd & sel_data & ~empty;
  assign flush   = wr & sel_ctrl & PWDATA[2];
  assign clr     = wr & sel_ctrl & PWDATA[1];
  assign push_ok = push_req & (~full | pop);
  assign ovr_ev  = push_req & full & ~pop & ~flush;

  assign PREADY    = access;
  assign Rx_Active = (state != S_IDLE);
  assign rx_irq    = enable & (~empty | frame_err
                     | overrun | timeout_err);

  // Two-flop synchronizer on the line; idle high out of reset
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      rx_s1 <= 1'b1;
      rx    <= 1'b1;
    end else begin
      rx_s1 <= Rx;
      rx    <= rx_s1;
    end
  end

`ifdef RX_TIMEOUT_EN
  localparam int TO_CYC = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW     = $clog2(TO_CYC + 1);

  logic [TW-1:0] idle_cnt;
  logic          idle_run;

  assign idle_run = enable && have_low
                    && state == S_IDLE;
  assign tmo_ev   = idle_run
                    && idle_cnt == TW'(TO_CYC - 1);

  // Idle time since the low byte of a packet was held
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN)
      idle_cnt <= '0;
    else if (idle_run && !tmo_ev)
      idle_cnt <= idle_cnt + 1'b1;
    else
      idle_cnt <= '0;
  end
`else
  logic unused_tmo;

  assign tmo_ev     = 1'b0;
  assign unused_tmo = (TIMEOUT_BITS > 0);
`endif

  // Frame FSM, bit sampling and byte pairing
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state     <= S_IDLE;
      armed     <= 1'b0;
      bit_cnt   <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      low_byte  <= '0;
      have_low  <= 1'b0;
      push_req  <= 1'b0;
      push_data <= '0;
    end else begin
      push_req <= 1'b0;
      if (!enable) begin
        state    <= S_IDLE;
        armed    <= 1'b0;
        have_low <= 1'b0;
      end else begin
        if (tmo_ev)
          have_low <= 1'b0;
        unique case (state)
          S_IDLE: begin
            if (rx) begin
              armed <= 1'b1;
            end else if (armed) begin
              state   <= S_START;
              bit_cnt <= HALF;
              armed   <= 1'b0;
            end
          end
          S_START: begin
            if (!expire) begin
              bit_cnt <= bit_cnt - 1'b1;
            end else if (!rx) begin
              state   <= S_DATA;
              bit_cnt <= FULL;
              bit_idx <= '0;
            end else begin
              state <= S_IDLE;
            end
          end
          S_DATA: begin
            if (!expire) begin
              bit_cnt <= bit_cnt - 1'b1;
            end else begin
              shreg   <= {rx, shreg[7:1]};
              bit_cnt <= FULL;
              if (bit_idx == 3'd7)
                state <= S_STOP;
              else
                bit_idx <= bit_idx + 1'b1;
            end
          end
          S_STOP: begin
            if (!expire) begin
              bit_cnt <= bit_cnt - 1'b1;
            end else begin
              state <= S_IDLE;
              if (!rx) begin
                have_low <= 1'b0;
              end else if (have_low) begin
                push_req  <= 1'b1;
                push_data <= {shreg, low_byte};
                have_low  <= 1'b0;
              end else begin
                low_byte <= shreg;
                have_low <= 1'b1;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // Packet FIFO; flush beats push, a pop makes room for a push
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Control and sticky errors; a new event beats a clear
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      enable      <= 1'b0;
      frame_err   <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (wr && sel_ctrl)
        enable <= PWDATA[0];
      frame_err   <= (frame_err & ~clr) | frame_ev;
      overrun     <= (overrun & ~clr) | ovr_ev;
      timeout_err <= (timeout_err & ~clr) | tmo_ev;
    end
  end

  // Zero-wait read mux, driven only in a read access phase
  always_comb begin
    PRDATA = '0;
    if (rd) begin
      unique case (1'b1)
        sel_data:
          PRDATA = empty ? 16'h0000 : mem[rd_ptr];
        sel_count:
          PRDATA = 16'(count);
        sel_status:
          PRDATA = {12'b0, timeout_err, overrun,
                    frame_err, empty};
        sel_ctrl:
          PRDATA = {15'b0, enable};
        default:
          PRDATA = '0;
      endcase
    end
  end

endmodule

// File: doc/rs485_apb_rx_controller.md
Name: rs485_apb_rx_controller

Overview:
- Receive-side counterpart of the RS485 APB transmit controller.
- Deserializes 8N1 UART frames from the RS485 transceiver Rx line and pairs consecutive bytes into 16-bit packets.
- Buffers packets in a FIFO that an APB master drains; also exposes occupancy, status and sticky error flags over APB.

Parameters:
- CLKS_PER_BIT, 16, PCLK cycles per bit period; must be ≥ 4 and even.
- FIFO_DEPTH, 16, packet entries in the receive FIFO; power of two.
- TIMEOUT_BITS, 20, bit periods of idle allowed between the low byte and high byte of a packet (used only with RX_TIMEOUT_EN).

Ports:
- PCLK  in  1  clock.
- PRESETN  in  1  asynchronous active-low reset.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB access phase.
- PWRITE  in  1  APB direction, 1 = write.
- PADDR  in  8  APB address.
- PWDATA  in  16  APB write data.
- PREADY  out  1  APB ready.
- PRDATA  out  16  APB read data.
- Rx  in  1  serial receive line, idle high.
- Rx_Active  out  1  high while a frame is being received (FSM not IDLE).
- rx_irq  out  1  high when the FIFO is non-empty or any sticky error is set, and enable = 1.

Behaviour:
- One clock, PCLK; reset is asynchronous and active-low on PRESETN.
- Reset state:
  - PREADY = 0, PRDATA = 0, Rx_Active = 0, rx_irq = 0.
  - FIFO empty; pointers and count = 0.
  - enable = 0; frame_err = 0, overrun = 0, timeout_err = 0; FSM in IDLE.
- Rx input: 2-flop synchronizer before any use. All timing below refers to the synchronized value.
- Bit counter: counts CLKS_PER_BIT-1 down to 0.
- FSM:
  - IDLE: armed only after the line has been seen high for at least 1 cycle. A low level moves to START and loads CLKS_PER_BIT/2-1.
  - START: on expiry, sample. Low → DATA (bit index 0, reload CLKS_PER_BIT-1). High → IDLE as a glitch, with no flag set.
  - DATA: on each expiry, sample into shift register LSB first. After bit 7 → STOP.
  - STOP: on expiry, sample. High → byte valid. Low → set frame_err, discard the byte and any held low byte, then go IDLE (which re-arms only on a high line).
- Packing:
  - The first valid byte is held as packet[7:0].
  - The second valid byte forms packet[15:8] and generates a push 1 cycle after the STOP sample.
- Push when FIFO full: packet dropped, overrun set, FIFO unchanged.
- enable = 0: FSM forced to IDLE, held low byte discarded, FIFO contents kept, APB reads still work.
- APB general:
  - PREADY = PSEL & PENABLE (zero wait states).
  - PRDATA is combinational in the access phase and 0 otherwise.
  - Unmapped addresses read 0; writes to them are ignored.
- APB register 0x00 RX_DATA (read):
  - Returns the FIFO head and pops 1 entry in the access cycle.
  - Empty FIFO: returns 0x0000, no pop, count stays 0.
- APB register 0x04 COUNT (read): returns occupancy 0..FIFO_DEPTH, zero-extended.
- APB register 0x08 STATUS (read): {12'b0, timeout_err, overrun, frame_err, empty}.
  - The full flag is derivable from COUNT.
- APB register 0x0C CTRL:
  - Write: bit0 = enable; bit1 = 1 clears all sticky errors (self-clearing); bit2 = 1 flushes the FIFO to empty.
  - Read: {15'b0, enable}.
- Simultaneous push and pop:
  - Both happen and count is unchanged.
  - When full, the pop frees the slot, so the push is accepted with no overrun.
  - When empty, the pop is ignored and the push lands, so count becomes 1.
- Simultaneous error-clear write and new error event: the event wins and the flag stays set.
- Flush in the same cycle as a push: flush wins, count = 0.
- Pointers wrap modulo FIFO_DEPTH; count is width $clog2(FIFO_DEPTH)+1.
- PRESETN asserted mid-frame: immediate return to reset state, partial data lost.

Optional Feature:
- RX_TIMEOUT_EN defined:
  - While a low byte is held, an idle counter runs in IDLE.
  - After TIMEOUT_BITS*CLKS_PER_BIT cycles without a new start bit, the held byte is discarded and timeout_err is set.
- RX_TIMEOUT_EN undefined:
  - No counter; a held low byte waits indefinitely.
  - STATUS bit3 reads 0 and TIMEOUT_BITS is unused.

Test Plan:
- Write CTRL=0x0001, drive bytes 0x34 then 0x12 at CLKS_PER_BIT=16 → COUNT=1, STATUS=0x0000, RX_DATA=0x1234, then COUNT=0, STATUS=0x0001.
- Send 17 packets (0x0001..0x0011) with no reads → COUNT=16, overrun=1 (STATUS=0x0004), reads return 0x0001..0x0010 in order, then a 17th read returns 0x0000.
- Byte 0xA5 with stop bit driven low, then 0x34, 0x12 → frame_err=1, only packet 0x1234 queued. CTRL=0x0003 → STATUS=0x0000 with FIFO non-empty (0x0001 while still queued).
- Rx low pulse of 4 cycles → returns to IDLE, no flag set, COUNT=0. Assert PRESETN low mid-DATA → all outputs at reset values, COUNT=0.
- FIFO full, second byte completes in the same cycle as an RX_DATA pop → COUNT stays 16, overrun=0.
- With RX_TIMEOUT_EN: byte 0x55, idle 21 bit times, then 0x34, 0x12 → timeout_err=1, RX_DATA=0x1234.
